debounce_multi: RTL and testbench

- Parametrised N-channel push-button debouncer; successor to the single-channel FSMD debouncer used in the ch06 test designs.
- Each channel has its own synchroniser, four-state FSM and down-counter timer.
- Each channel outputs a debounced level, a press tick and a release tick. An optional hold-to-repeat tick can be compiled in.
- Sits between the board button pins and counters, menus or paddle logic; replaces per-button debounce instances plus hand-written polarity inversion.

---
 rtl/debounce_multi.sv | 165 ++++++++++++++++
 tb/tb_debounce_multi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : debounce_multi                                                    |
// | N-channel push-button debouncer: 2-flop synchroniser, 4-state FSM and      |
// | down-counter per channel; registered level, press and release ticks.       |
// | Optional hold-to-repeat tick compiled in with macro DEBOUNCE_REPEAT_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debounce_multi #(
    parameter int N          = 2,
    parameter int DB_CYCLES  = 1000000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_PERIOD = 10000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn,
    output logic [N-1:0] db_level,
    output logic [N-1:0] rise_tick,
    output logic [N-1:0] fall_tick,
    output logic [N-1:0] rep_tick
);

    localparam int                   c_TIMER_W    = $clog2(DB_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LOAD = c_TIMER_W'(DB_CYCLES - 1);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int                 c_REP_MAX   = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int                 c_REP_W     = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
    localparam logic [c_REP_W-1:0] c_REP_DELAY_LOAD  = c_REP_W'(REP_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_REP_PERIOD_LOAD = c_REP_W'(REP_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    if (DB_CYCLES < 2 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
        $error("debounce_multi: illegal parameter value");
    end

    // Polarity is normalised before the synchroniser so every FSM sees 1 = pressed.
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn ^ {N{ACTIVE_LOW}};
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t               r_state;
        state_t               w_state_next;
        logic [c_TIMER_W-1:0] r_timer;
        logic [c_TIMER_W-1:0] w_timer_next;
        logic                 w_rise;
        logic                 w_fall;
        logic                 r_level;
        logic                 r_rise;
        logic                 r_fall;

        always_comb begin
            w_state_next = r_state;
            w_timer_next = r_timer;
            w_rise       = 1'b0;
            w_fall       = 1'b0;
            case (r_state)
                ZERO: begin
                    if (r_sync2[i]) begin
                        w_state_next = WAIT1;
                        w_timer_next = c_TIMER_LOAD;
                    end
                end
                WAIT1: begin
                    if (!r_sync2[i]) begin
                        w_state_next = ZERO;
                    end else if (r_timer == '0) begin
                        w_state_next = ONE;
                        w_rise       = 1'b1;
                    end else begin
                        w_timer_next = r_timer - c_TIMER_W'(1);
                    end
                end
                ONE: begin
                    if (!r_sync2[i]) begin
                        w_state_next = WAIT0;
                        w_timer_next = c_TIMER_LOAD;
                    end
                end
                WAIT0: begin
                    if (r_sync2[i]) begin
                        w_state_next = ONE;
                    end else if (r_timer == '0) begin
                        w_state_next = ZERO;
                        w_fall       = 1'b1;
                    end else begin
                        w_timer_next = r_timer - c_TIMER_W'(1);
                    end
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ZERO;
                r_timer <= '0;
                r_level <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_timer <= w_timer_next;
                r_level <= (w_state_next == ONE) || (w_state_next == WAIT0);
                r_rise  <= w_rise;
                r_fall  <= w_fall;
            end
        end

        assign db_level[i]  = r_level;
        assign rise_tick[i] = r_rise;
        assign fall_tick[i] = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
        // Counter freezes through release bounces (WAIT0) so a brief chatter does not restart the repeat cadence.
        logic [c_REP_W-1:0] r_rep_cnt;
        logic               r_rep;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rep_cnt <= '0;
                r_rep     <= 1'b0;
            end else begin
                r_rep <= 1'b0;
                if (w_rise) begin
                    r_rep_cnt <= c_REP_DELAY_LOAD;
                end else if (w_state_next == ZERO) begin
                    r_rep_cnt <= '0;
                end else if (r_state == ONE) begin
                    if (r_rep_cnt == '0) begin
                        r_rep     <= 1'b1;
                        r_rep_cnt <= c_REP_PERIOD_LOAD;
                    end else begin
                        r_rep_cnt <= r_rep_cnt - c_REP_W'(1);
                    end
                end
            end
        end

        assign rep_tick[i] = r_rep;
`else
        assign rep_tick[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_debounce_multi                                                 |
// | Scoreboard bench for debounce_multi (N=2, DB_CYCLES=4, ACTIVE_LOW=0).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_debounce_multi;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn;
    logic [N-1:0] db_level;
    logic [N-1:0] rise_tick;
    logic [N-1:0] fall_tick;
    logic [N-1:0] rep_tick;

    debounce_multi #(
        .N          (N),
        .DB_CYCLES  (4),
        .ACTIVE_LOW (1'b0),
        .REP_DELAY  (10),
        .REP_PERIOD (3)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .rep_tick  (rep_tick)
    );

    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         edge_n;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] rep;
    } ev_t;

    ev_t        sb[$];
    logic [1:0] lvl = 2'b00;
    int         checks = 0;
    int         errors = 0;

    task automatic test_reset();
        reset = 1'b1;
        btn   = 2'b00;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if ({db_level, rise_tick, fall_tick, rep_tick} !== 8'h00) begin
                errors++;
                $display("FAIL reset_state edge %0d: lvl/rise/fall/rep got %b/%b/%b/%b want all 0",
                         cyc, db_level, rise_tick, fall_tick, rep_tick);
            end
        end
        reset = 1'b0;
        lvl   = 2'b00;
    endtask

    task automatic test_glitch();
        ev_t e;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            e = '{cyc, 2'b00, 2'b00, 2'b00};
            if (sb.size() > 0 && sb[0].edge_n == cyc) e = sb.pop_front();
            lvl = (lvl | e.rise) & ~e.fall;
            checks++;
            if ({rise_tick, fall_tick, rep_tick} !== {e.rise, e.fall, e.rep}) begin
                errors++;
                $display("FAIL glitch_ticks edge %0d: rise/fall/rep got %b/%b/%b want %b/%b/%b",
                         cyc, rise_tick, fall_tick, rep_tick, e.rise, e.fall, e.rep);
            end
            checks++;
            if (db_level !== lvl) begin
                errors++;
                $display("FAIL glitch_level edge %0d: got %b want %b", cyc, db_level, lvl);
            end
            btn = (t < 3) ? 2'b01 : 2'b00;
        end
    endtask

    task automatic test_clean_press();
        ev_t e;
        for (int t = 0; t < 22; t++) begin
            @(negedge clk);
            e = '{cyc, 2'b00, 2'b00, 2'b00};
            if (sb.size() > 0 && sb[0].edge_n == cyc) e = sb.pop_front();
            lvl = (lvl | e.rise) & ~e.fall;
            checks++;
            if ({rise_tick, fall_tick, rep_tick} !== {e.rise, e.fall, e.rep}) begin
                errors++;
                $display("FAIL press_ticks edge %0d: rise/fall/rep got %b/%b/%b want %b/%b/%b",
                         cyc, rise_tick, fall_tick, rep_tick, e.rise, e.fall, e.rep);
            end
            checks++;
            if (db_level !== lvl) begin
                errors++;
                $display("FAIL press_level edge %0d: got %b want %b", cyc, db_level, lvl);
            end
            if (t == 0) begin
                btn = 2'b01;
                sb.push_back('{cyc + 7, 2'b01, 2'b00, 2'b00});
            end
            if (t == 12) begin
                btn = 2'b00;
                sb.push_back('{cyc + 7, 2'b00, 2'b01, 2'b00});
            end
        end
    endtask

    task automatic test_bouncy_release();
        ev_t e;
        for (int t = 0; t < 26; t++) begin
            @(negedge clk);
            e = '{cyc, 2'b00, 2'b00, 2'b00};
            if (sb.size() > 0 && sb[0].edge_n == cyc) e = sb.pop_front();
            lvl = (lvl | e.rise) & ~e.fall;
            checks++;
            if ({rise_tick, fall_tick, rep_tick} !== {e.rise, e.fall, e.rep}) begin
                errors++;
                $display("FAIL bounce_ticks edge %0d: rise/fall/rep got %b/%b/%b want %b/%b/%b",
                         cyc, rise_tick, fall_tick, rep_tick, e.rise, e.fall, e.rep);
            end
            checks++;
            if (db_level !== lvl) begin
                errors++;
                $display("FAIL bounce_level edge %0d: got %b want %b", cyc, db_level, lvl);
            end
            // Low 2 / high 1 / low 2 once the channel is in ONE, then steady high, then a real release.
            case (t)
                0:       begin btn = 2'b01; sb.push_back('{cyc + 7, 2'b01, 2'b00, 2'b00}); end
                5, 6:    btn = 2'b00;
                7:       btn = 2'b01;
                8, 9:    btn = 2'b00;
                10:      btn = 2'b01;
                15:      begin btn = 2'b00; sb.push_back('{cyc + 7, 2'b00, 2'b01, 2'b00}); end
                default: ;
            endcase
        end
    endtask

    task automatic test_independence();
        ev_t e;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            e = '{cyc, 2'b00, 2'b00, 2'b00};
            if (sb.size() > 0 && sb[0].edge_n == cyc) e = sb.pop_front();
            lvl = (lvl | e.rise) & ~e.fall;
            checks++;
            if ({rise_tick, fall_tick, rep_tick} !== {e.rise, e.fall, e.rep}) begin
                errors++;
                $display("FAIL indep_ticks edge %0d: rise/fall/rep got %b/%b/%b want %b/%b/%b",
                         cyc, rise_tick, fall_tick, rep_tick, e.rise, e.fall, e.rep);
            end
            checks++;
            if (db_level !== lvl) begin
                errors++;
                $display("FAIL indep_level edge %0d: got %b want %b", cyc, db_level, lvl);
            end
            case (t)
                0:       begin btn = 2'b11; sb.push_back('{cyc + 7, 2'b11, 2'b00, 2'b00}); end
                5:       begin btn = 2'b01; sb.push_back('{cyc + 7, 2'b00, 2'b10, 2'b00}); end
                6:       begin btn = 2'b00; sb.push_back('{cyc + 7, 2'b00, 2'b01, 2'b00}); end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_wait1();
        ev_t e;
        for (int t = 0; t < 24; t++) begin
            @(negedge clk);
            e = '{cyc, 2'b00, 2'b00, 2'b00};
            if (sb.size() > 0 && sb[0].edge_n == cyc) e = sb.pop_front();
            lvl = (lvl | e.rise) & ~e.fall;
            checks++;
            if ({rise_tick, fall_tick, rep_tick} !== {e.rise, e.fall, e.rep}) begin
                errors++;
                $display("FAIL rstwait_ticks edge %0d: rise/fall/rep got %b/%b/%b want %b/%b/%b",
                         cyc, rise_tick, fall_tick, rep_tick, e.rise, e.fall, e.rep);
            end
            checks++;
            if (db_level !== lvl) begin
                errors++;
                $display("FAIL rstwait_level edge %0d: got %b want %b", cyc, db_level, lvl);
            end
            // WAIT1 is entered at edge c+3; the reset edge c+5 lands two cycles into it.
            case (t)
                0:       btn = 2'b01;
                4:       begin reset = 1'b1; sb.push_back('{cyc + 8, 2'b01, 2'b00, 2'b00}); end
                5:       reset = 1'b0;
                14:      begin btn = 2'b00; sb.push_back('{cyc + 7, 2'b00, 2'b01, 2'b00}); end
                default: ;
            endcase
        end
    endtask

    task automatic test_repeat();
        ev_t e;
        for (int t = 0; t < 34; t++) begin
            @(negedge clk);
            e = '{cyc, 2'b00, 2'b00, 2'b00};
            if (sb.size() > 0 && sb[0].edge_n == cyc) e = sb.pop_front();
            lvl = (lvl | e.rise) & ~e.fall;
            checks++;
            if ({rise_tick, fall_tick, rep_tick} !== {e.rise, e.fall, e.rep}) begin
                errors++;
                $display("FAIL repeat_ticks edge %0d: rise/fall/rep got %b/%b/%b want %b/%b/%b",
                         cyc, rise_tick, fall_tick, rep_tick, e.rise, e.fall, e.rep);
            end
            checks++;
            if (db_level !== lvl) begin
                errors++;
                $display("FAIL repeat_level edge %0d: got %b want %b", cyc, db_level, lvl);
            end
            if (t == 0) begin
                btn = 2'b01;
                sb.push_back('{cyc + 7, 2'b01, 2'b00, 2'b00});
`ifdef DEBOUNCE_REPEAT_EN
                // First repeat 10 cycles after the press tick, then every 3 while still in ONE.
                for (int k = 0; k < 4; k++) sb.push_back('{cyc + 17 + 3 * k, 2'b00, 2'b00, 2'b01});
`endif
            end
            if (t == 24) begin
                btn = 2'b00;
                sb.push_back('{cyc + 7, 2'b00, 2'b01, 2'b00});
            end
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending events want 0 (next due edge %0d)",
                     name, sb.size(), sb[0].edge_n);
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        check_drained("glitch");
        test_clean_press();
        check_drained("press");
        test_bouncy_release();
        check_drained("bounce");
        test_independence();
        check_drained("indep");
        test_reset_mid_wait1();
        check_drained("rstwait");
        test_repeat();
        check_drained("repeat");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
